// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch flushes and the
// multdiv stall/release sequence for a five-stage pipeline.
module pipe_hazard_ctrl #(
   parameter int MD_TIMEOUT = 40
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] FDB,
   input  logic [31:0] DXB,
   input  logic        md_op,
   input  logic        md_ready,
   input  logic        branch_taken,
   output logic        fd_en,
   output logic        dx_en,
   output logic        xm_en,
   output logic        mw_en,
   output logic        fd_flush,
   output logic        dx_flush,
   output logic        xm_flush,
   output logic        md_start,
   output logic        md_busy,
   output logic        stall,
   output logic        md_timeout
);

   typedef enum logic [1:0] {RUN, MD_WAIT, MD_DONE} state_t;

   localparam logic [5:0] CountLast = 6'(MD_TIMEOUT - 1);
   localparam logic [5:0] CountMax  = 6'h3f;

   state_t     state;
   logic [5:0] count;
   logic [4:0] dxRd;
   logic       loadUse;
   logic       unusedBits;

   // A store reads rB only as data to write, which the decode stage does not need yet.
   assign dxRd    = DXB[14:10];
   assign loadUse = DXB[29] && (dxRd != 5'd0) &&
                    ((FDB[4:0] == dxRd) || ((FDB[9:5] == dxRd) && !FDB[30]));

   assign unusedBits = ^{FDB[31], FDB[29:10], DXB[31:30], DXB[28:15], DXB[9:0]};

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= RUN;
         count      <= 6'd0;
         md_timeout <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (!branch_taken && md_op) begin
                  state <= MD_WAIT;
                  count <= 6'd0;
               end
            end
            MD_WAIT: begin
               if (md_ready) begin
                  state <= MD_DONE;
               end else begin
                  if (count != CountMax) begin
                     count <= count + 6'd1;
                  end
                  if (count == CountLast) begin
                     md_timeout <= 1'b1;
                     state      <= MD_DONE;
                  end
               end
            end
            MD_DONE: state <= RUN;
            default: state <= RUN;
         endcase
      end
   end

   // Outputs are Mealy: they follow the current inputs within the cycle.
   always_comb begin
      fd_en    = 1'b1;
      dx_en    = 1'b1;
      xm_en    = 1'b1;
      mw_en    = 1'b1;
      fd_flush = 1'b0;
      dx_flush = 1'b0;
      xm_flush = 1'b0;
      md_start = 1'b0;
      md_busy  = 1'b0;
      case (state)
         RUN: begin
            if (branch_taken) begin
               fd_flush = 1'b1;
               dx_flush = 1'b1;
            end else if (md_op) begin
               md_start = 1'b1;
               fd_en    = 1'b0;
               dx_en    = 1'b0;
               xm_flush = 1'b1;
            end else if (loadUse) begin
               fd_en    = 1'b0;
               dx_flush = 1'b1;
            end
         end
         MD_WAIT: begin
            fd_en    = 1'b0;
            dx_en    = 1'b0;
            xm_flush = 1'b1;
            md_busy  = 1'b1;
         end
         default: ;
      endcase
   end

   assign stall = !fd_en;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus random
// traffic, checked against a behavioural model of the hazard rules.
module tb_pipe_hazard_ctrl;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] FDB = '0;
   logic [31:0] DXB = '0;
   logic        md_op = 1'b0;
   logic        md_ready = 1'b0;
   logic        branch_taken = 1'b0;

   logic aFdEn, aDxEn, aXmEn, aMwEn, aFdFl, aDxFl, aXmFl, aStart, aBusy, aStall, aTmo;
   logic bFdEn, bDxEn, bXmEn, bMwEn, bFdFl, bDxFl, bXmFl, bStart, bBusy, bStall, bTmo;

   // Output vector layout: {fd_en,dx_en,xm_en,mw_en,fd_flush,dx_flush,xm_flush,md_start,md_busy,stall,md_timeout}
   logic [10:0] outA, outB, expA, expB;
   assign outA = {aFdEn, aDxEn, aXmEn, aMwEn, aFdFl, aDxFl, aXmFl, aStart, aBusy, aStall, aTmo};
   assign outB = {bFdEn, bDxEn, bXmEn, bMwEn, bFdFl, bDxFl, bXmFl, bStart, bBusy, bStall, bTmo};

   int checks = 0;
   int failures = 0;

   // Model: mode 0 = running, 1 = waiting on multdiv, 2 = result capture cycle.
   int mode[2];
   int waited[2];
   bit tflag[2];
   int limit[2] = '{40, 4};

   pipe_hazard_ctrl dutA (
      .clock(clock), .reset(reset), .FDB(FDB), .DXB(DXB), .md_op(md_op),
      .md_ready(md_ready), .branch_taken(branch_taken),
      .fd_en(aFdEn), .dx_en(aDxEn), .xm_en(aXmEn), .mw_en(aMwEn),
      .fd_flush(aFdFl), .dx_flush(aDxFl), .xm_flush(aXmFl),
      .md_start(aStart), .md_busy(aBusy), .stall(aStall), .md_timeout(aTmo));

   pipe_hazard_ctrl #(.MD_TIMEOUT(4)) dutB (
      .clock(clock), .reset(reset), .FDB(FDB), .DXB(DXB), .md_op(md_op),
      .md_ready(md_ready), .branch_taken(branch_taken),
      .fd_en(bFdEn), .dx_en(bDxEn), .xm_en(bXmEn), .mw_en(bMwEn),
      .fd_flush(bFdFl), .dx_flush(bDxFl), .xm_flush(bXmFl),
      .md_start(bStart), .md_busy(bBusy), .stall(bStall), .md_timeout(bTmo));

   always #5 clock = ~clock;

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   function automatic logic [31:0] mk(input int rA, input int rB, input int rd,
                                      input bit lw, input bit sw, input bit r30);
      logic [31:0] w;
      w        = $urandom;
      w[4:0]   = 5'(rA);
      w[9:5]   = 5'(rB);
      w[14:10] = 5'(rd);
      w[29]    = lw;
      w[30]    = sw;
      w[31]    = r30;
      return w;
   endfunction

   function automatic logic [10:0] refOut(input int m, input bit t, input logic [31:0] f,
                                          input logic [31:0] d, input bit md, input bit br);
      bit hz;
      hz = d[29] && (d[14:10] != 0) &&
           ((f[4:0] == d[14:10]) || ((f[9:5] == d[14:10]) && !f[30]));
      if (m == 1) return {4'b0011, 3'b001, 1'b0, 1'b1, 1'b1, t};
      if (m == 2) return {4'b1111, 3'b000, 1'b0, 1'b0, 1'b0, t};
      if (br)     return {4'b1111, 3'b110, 1'b0, 1'b0, 1'b0, t};
      if (md)     return {4'b0011, 3'b001, 1'b1, 1'b0, 1'b1, t};
      if (hz)     return {4'b0111, 3'b010, 1'b0, 1'b0, 1'b1, t};
      return {4'b1111, 3'b000, 1'b0, 1'b0, 1'b0, t};
   endfunction

   task automatic modelReset();
      for (int i = 0; i < 2; i++) begin
         mode[i] = 0;
         waited[i] = 0;
         tflag[i] = 0;
      end
   endtask

   task automatic computeExp();
      expA = refOut(mode[0], tflag[0], FDB, DXB, md_op, branch_taken);
      expB = refOut(mode[1], tflag[1], FDB, DXB, md_op, branch_taken);
   endtask

   // Inputs are driven 1 time unit after the rising edge and sampled 3 units later.
   task automatic applyStimulus(input logic [31:0] f, input logic [31:0] d,
                                input bit md, input bit rdy, input bit br);
      FDB = f;
      DXB = d;
      md_op = md;
      md_ready = rdy;
      branch_taken = br;
      #3;
      computeExp();
   endtask

   task automatic advance();
      @(posedge clock);
      if (!reset) begin
         modelReset();
      end else begin
         for (int i = 0; i < 2; i++) begin
            case (mode[i])
               0: if (!branch_taken && md_op) begin
                     mode[i] = 1;
                     waited[i] = 0;
                  end
               1: begin
                     waited[i]++;
                     if (md_ready) mode[i] = 2;
                     else if (waited[i] == limit[i]) begin
                        tflag[i] = 1;
                        mode[i] = 2;
                     end
                  end
               default: mode[i] = 0;
            endcase
         end
      end
      #1;
   endtask

   task automatic pulseReset();
      reset = 1'b0;
      advance();
      reset = 1'b1;
   endtask

   task automatic test_reset();
      applyStimulus(mk(3, 4, 0, 0, 0, 0), mk(0, 0, 3, 1, 0, 0), 1'b1, 1'b0, 1'b0);
      checks++;
      if (outA !== expA) begin
         failures++;
         $display("[TB] FAIL reset_outputs got=%b want=%b", outA, expA);
      end
      advance();
      applyStimulus('0, '0, 1'b0, 1'b0, 1'b0);
      checks++;
      if ({outA[2], outA[0], outB[2], outB[0]} !== 4'b0000) begin
         failures++;
         $display("[TB] FAIL reset_idle got=%b%b%b%b want=0000", outA[2], outA[0], outB[2], outB[0]);
      end
      reset = 1'b1;
      #1;
      checks++;
      if (outA !== 11'b11110000000) begin
         failures++;
         $display("[TB] FAIL first_run_cycle got=%b want=11110000000", outA);
      end
      advance();
   endtask

   task automatic test_load_use();
      applyStimulus(mk(5, 9, 1, 0, 0, 0), mk(2, 2, 5, 1, 0, 0), 1'b0, 1'b0, 1'b0);
      checks++;
      if (outA !== expA || outA[1] !== 1'b1 || outA[5] !== 1'b1 || outA[10] !== 1'b0) begin
         failures++;
         $display("[TB] FAIL load_use_stall got=%b want=%b", outA, expA);
      end
      advance();
      applyStimulus(mk(5, 9, 1, 0, 0, 0), '0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (outA !== 11'b11110000000) begin
         failures++;
         $display("[TB] FAIL load_use_release got=%b want=11110000000", outA);
      end
      advance();
      applyStimulus(mk(0, 0, 1, 0, 0, 0), mk(2, 2, 0, 1, 0, 1), 1'b0, 1'b0, 1'b0);
      checks++;
      if (outA[1] !== 1'b0 || outA !== expA) begin
         failures++;
         $display("[TB] FAIL r0_no_hazard got=%b want=%b", outA, expA);
      end
      advance();
   endtask

   task automatic test_sw_rb();
      applyStimulus(mk(3, 7, 0, 0, 1, 0), mk(1, 1, 7, 1, 0, 0), 1'b0, 1'b0, 1'b0);
      checks++;
      if (outA[1] !== 1'b0 || outA !== expA) begin
         failures++;
         $display("[TB] FAIL sw_rb_no_stall got=%b want=%b", outA, expA);
      end
      advance();
      applyStimulus(mk(7, 3, 0, 0, 1, 0), mk(1, 1, 7, 1, 0, 0), 1'b0, 1'b0, 1'b0);
      checks++;
      if (outA[1] !== 1'b1 || outA !== expA) begin
         failures++;
         $display("[TB] FAIL sw_ra_stall got=%b want=%b", outA, expA);
      end
      advance();
      applyStimulus(mk(3, 7, 0, 0, 0, 1), mk(1, 1, 7, 1, 0, 1), 1'b0, 1'b0, 1'b0);
      checks++;
      if (outA[1] !== 1'b1 || outA !== expA) begin
         failures++;
         $display("[TB] FAIL alu_rb_stall got=%b want=%b", outA, expA);
      end
      advance();
   endtask

   task automatic test_multdiv();
      int busyCycles = 0;
      pulseReset();
      applyStimulus(mk(1, 2, 3, 0, 0, 0), mk(4, 5, 6, 0, 0, 0), 1'b1, 1'b0, 1'b0);
      checks++;
      if (outA !== expA || outA[3] !== 1'b1) begin
         failures++;
         $display("[TB] FAIL md_start got=%b want=%b", outA, expA);
      end
      advance();
      for (int i = 1; i <= 5; i++) begin
         applyStimulus($urandom, $urandom, 1'b0, (i == 5), (i == 2));
         if (outA[2] === 1'b1) busyCycles++;
         checks++;
         if (outA !== expA || outA[3] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL md_wait_%0d got=%b want=%b", i, outA, expA);
         end
         advance();
      end
      checks++;
      if (busyCycles != 5) begin
         failures++;
         $display("[TB] FAIL md_busy_len got=%0d want=5", busyCycles);
      end
      applyStimulus(mk(5, 5, 5, 0, 0, 0), mk(0, 0, 5, 1, 0, 0), 1'b1, 1'b0, 1'b1);
      checks++;
      if (outA !== 11'b11110000000) begin
         failures++;
         $display("[TB] FAIL md_done got=%b want=11110000000", outA);
      end
      advance();
      applyStimulus('0, '0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (outA !== expA || outA[2] !== 1'b0) begin
         failures++;
         $display("[TB] FAIL md_back_to_run got=%b want=%b", outA, expA);
      end
      advance();
   endtask

   task automatic test_timeout();
      pulseReset();
      applyStimulus('0, '0, 1'b1, 1'b0, 1'b0);
      advance();
      for (int i = 1; i <= 4; i++) begin
         applyStimulus($urandom, $urandom, 1'b0, 1'b0, 1'b0);
         checks++;
         if (outB[2] !== 1'b1 || outB[0] !== 1'b0 || outB !== expB) begin
            failures++;
            $display("[TB] FAIL timeout_wait_%0d got=%b want=%b", i, outB, expB);
         end
         advance();
      end
      for (int i = 0; i < 3; i++) begin
         applyStimulus('0, '0, 1'b0, 1'b0, 1'b0);
         checks++;
         if (outB[0] !== 1'b1 || outB[2] !== 1'b0 || outB !== expB) begin
            failures++;
            $display("[TB] FAIL timeout_after_%0d got=%b want=%b", i, outB, expB);
         end
         advance();
      end
      checks++;
      if (outA[0] !== 1'b0 || outA[2] !== 1'b1) begin
         failures++;
         $display("[TB] FAIL long_limit_still_busy got=%b want busy=1 tmo=0", outA);
      end
   endtask

   task automatic test_priority();
      pulseReset();
      applyStimulus(mk(5, 1, 2, 0, 0, 0), mk(0, 0, 5, 1, 0, 0), 1'b1, 1'b0, 1'b1);
      checks++;
      if (outA !== expA || outA !== 11'b11111100000) begin
         failures++;
         $display("[TB] FAIL branch_priority got=%b want=11111100000", outA);
      end
      advance();
      applyStimulus('0, '0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (outA[2] !== 1'b0 || outA !== expA) begin
         failures++;
         $display("[TB] FAIL branch_no_md got=%b want=%b", outA, expA);
      end
      advance();
   endtask

   task automatic test_async_reset();
      pulseReset();
      applyStimulus('0, '0, 1'b1, 1'b0, 1'b0);
      advance();
      applyStimulus('0, '0, 1'b0, 1'b0, 1'b0);
      advance();
      applyStimulus(mk(1, 1, 1, 0, 0, 0), '0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (outA[2] !== 1'b1) begin
         failures++;
         $display("[TB] FAIL async_pre_busy got=%b want=1", outA[2]);
      end
      reset = 1'b0;
      #1;
      modelReset();
      computeExp();
      checks++;
      if (outA !== expA || outA !== 11'b11110000000 || outB !== expB) begin
         failures++;
         $display("[TB] FAIL async_reset_run got=%b/%b want=%b/%b", outA, outB, expA, expB);
      end
      advance();
      reset = 1'b1;
      advance();
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         applyStimulus(mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 31),
                          $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1)),
                       mk($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 3),
                          $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1)),
                       ($urandom_range(0, 5) == 0), ($urandom_range(0, 4) == 0),
                       ($urandom_range(0, 7) == 0));
         checks++;
         if (outA !== expA || outB !== expB) begin
            failures++;
            $display("[TB] FAIL random_%0d got=%b/%b want=%b/%b", n, outA, outB, expA, expB);
         end
         advance();
      end
   endtask

   initial begin
      modelReset();
      test_reset();
      test_load_use();
      test_sw_rb();
      test_multdiv();
      test_timeout();
      test_priority();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter: MD_TIMEOUT, default 40, legal range 2..63; maximum number of MD_WAIT cycles before a forced release.
REQ-002 The clock port SHALL be `clock`, input, 1 bit; this is the single clock, and all state updates on its rising edge.
REQ-003 The reset port SHALL be `reset`, input, 1 bit; reset is asynchronous and active-low.
REQ-004 FDB, input, 32 bits: bypass word of the instruction in decode. Fields: [4:0] rA, [9:5] rB, [14:10] rd, [29] lw, [30] sw, [31] writes r30.
REQ-005 DXB, input, 32 bits: bypass word of the instruction in execute, same field layout as FDB.
REQ-006 md_op, input, 1 bit: the execute-stage instruction is a mult or div.
REQ-007 md_ready, input, 1 bit: the multdiv unit result is valid this cycle.
REQ-008 branch_taken, input, 1 bit: execute-stage redirect (branch or jump) resolved this cycle.
REQ-009 fd_en, dx_en, xm_en, mw_en, outputs, 1 bit each: pipeline latch write enables.
REQ-010 fd_flush, dx_flush, xm_flush, outputs, 1 bit each: load a NOP into the named latch at the next edge.
REQ-011 md_start, output, 1 bit: single-cycle start pulse to the multdiv unit.
REQ-012 md_busy, output, 1 bit: high while in MD_WAIT.
REQ-013 stall, output, 1 bit: high whenever fd_en=0.
REQ-014 md_timeout, output, 1 bit: sticky flag set by a timeout.

Function
REQ-015 The FSM SHALL have three states: RUN, MD_WAIT, MD_DONE; its encoding is free.
REQ-016 Load-use hazard (lu) SHALL be defined as: DXB[29]=1 & DXB[14:10]!=0 & (FDB[4:0]==DXB[14:10] | (FDB[9:5]==DXB[14:10] & FDB[30]=0)).
REQ-017 RUN with branch_taken=1 (highest priority): all enables=1, fd_flush=1, dx_flush=1, md_start=0, next state RUN; this holds regardless of md_op or lu.
REQ-018 RUN, else if md_op=1: md_start=1, fd_en=dx_en=0, xm_flush=1, mw_en=1, next state MD_WAIT, cycle counter cleared to 0.
REQ-019 RUN, else if lu=1: fd_en=0, dx_flush=1, xm_en=mw_en=1, next state RUN (exactly one bubble).
REQ-020 RUN, otherwise: all enables=1, all flushes=0.
REQ-021 MD_WAIT outputs SHALL be: fd_en=dx_en=0, xm_flush=1, mw_en=1, md_busy=1, md_start=0; branch_taken is ignored.
REQ-022 MD_WAIT with md_ready=1: next state MD_DONE.
REQ-023 MD_WAIT with md_ready=0: the counter increments; when the counter equals MD_TIMEOUT-1, md_timeout is set and the next state is MD_DONE.
REQ-024 MD_DONE SHALL drive all enables=1 and all flushes=0 for one cycle, so the result is captured into XM.
REQ-025 MD_DONE SHALL ignore md_op, lu and branch_taken, and its next state SHALL be RUN.
REQ-026 The counter SHALL be 6 bits wide, SHALL saturate and never wrap, and SHALL be cleared on every entry to MD_WAIT.
REQ-027 Outputs SHALL be a function of state plus the current inputs (Mealy) only; no output is registered except md_timeout.
REQ-028 Register 0 SHALL never create a hazard; r30 writes (bit 31) do not affect hazard detection.

Reset
REQ-029 While reset=0: state=RUN, counter=0, md_timeout=0.
REQ-030 On reset assertion mid-MD_WAIT, the block SHALL return to RUN immediately with md_busy=0 and no md_start pulse.
REQ-031 The first post-reset cycle SHALL behave as RUN, with outputs evaluated normally.

Verification
REQ-032 Load-use: DXB lw rd=5, FDB rA=5 -> one cycle fd_en=0, dx_flush=1, stall=1, then normal flow; the same with rd=0 -> no stall.
REQ-033 sw rB match: DXB lw rd=7, FDB sw with rB=7 and rA=3 -> no stall; FDB sw with rA=7 -> stall.
REQ-034 Multdiv: md_op=1, md_ready after 5 wait cycles -> md_start for exactly 1 cycle, md_busy for 5 cycles, one MD_DONE cycle with all enables=1, then RUN.
REQ-035 Timeout: MD_TIMEOUT=4, md_ready held 0 -> 4 MD_WAIT cycles, then MD_DONE, and md_timeout=1 until reset.
REQ-036 Priority: branch_taken=1 with md_op=1 and lu=1 -> fd_flush=dx_flush=1, md_start=0, stall=0.
REQ-037 Async reset: drop reset in the 2nd MD_WAIT cycle -> outputs reflect RUN before the next clock edge; md_timeout=0.
